// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
// The address is registered by the fetch stage and held while the request is pending.
interface instr_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch FSM, and a two-entry output/skid buffer.
// Feeds the IF/ID register via if_write, instr_out and next_pc_out.
module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  instr_fetch_stage_if.master  imem,
  output logic                 if_write,
  output logic [DATA_W-1:0]    instr_out,
  output logic [ADDR_W-1:0]    next_pc_out
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] npc;
  } entry_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, fetch_addr, fetch_inc, rpc;
  entry_t            out_q, skid_q, new_e;
  logic              out_valid, skid_valid;
  logic              consume, accept;
  logic [1:0]        occ_nxt;

  assign rpc       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fetch_inc = fetch_addr + ADDR_W'(4);
  assign if_write  = out_valid & ~stall & ~redirect;
  assign consume   = if_write;
  assign accept    = (state == REQ) & imem.imem_ack & ~redirect;
  assign new_e     = '{instr: imem.imem_rdata, npc: fetch_inc};

  // Buffer occupancy after this edge (redirect flushes separately)
  assign occ_nxt = {1'b0, out_valid} + {1'b0, skid_valid}
                 - {1'b0, consume}   + {1'b0, accept};

  assign imem.imem_addr = fetch_addr;
  assign instr_out      = out_q.instr;
  assign next_pc_out    = out_q.npc;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (redirect || occ_nxt < 2'd2) state_nxt = REQ;
      REQ: begin
        if (redirect)                             state_nxt = imem.imem_ack ? REQ : DRAIN;
        else if (imem.imem_ack && occ_nxt >= 2'd2) state_nxt = IDLE;
      end
      DRAIN: if (imem.imem_ack) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = (state != IDLE);
  end

  // pc tracks the architectural next fetch; fetch_addr lags it only while draining
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else if (redirect) begin
      pc <= rpc;
      if (state == IDLE || imem.imem_ack) fetch_addr <= rpc;
    end else if (accept) begin
      pc         <= fetch_inc;
      fetch_addr <= fetch_inc;
    end else if (state == DRAIN && imem.imem_ack) begin
      fetch_addr <= pc;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (redirect) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        skid_valid <= accept;
        if (accept) skid_q <= new_e;
      end else if (accept) begin
        out_q <= new_e;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_q     <= new_e;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= new_e;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios then random stall/redirect/ack-delay
// traffic, checked against an instruction-stream model (expected address sequence).
module tb_instr_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_write, if_write2;
  logic [31:0] instr_out, next_pc_out, instr2, npc2;

  int total = 0;
  int bad = 0;
  int consumed = 0;
  logic [31:0] exp_addr = 32'h0;

  int   dly = 0;
  bit   rnd_dly = 1'b0;
  int   cnt = 0;
  bit   prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  instr_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem ();
  instr_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem2 ();

  always #5 clock = ~clock;

  instr_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .clear_n(clear_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem), .if_write(if_write),
    .instr_out(instr_out), .next_pc_out(next_pc_out)
  );

  instr_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .clear_n(clear_n), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem(imem2), .if_write(if_write2),
    .instr_out(instr2), .next_pc_out(npc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Memory model: ack after dly idle request cycles, data = addr ^ K
  initial begin
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (clear_n && prev_hold && imem.imem_req) chk("addr_hold", imem.imem_addr, prev_addr);
      if (clear_n && imem.imem_req) begin
        if (cnt >= dly) begin
          imem.imem_ack = 1'b1;
          imem.imem_rdata = imem.imem_addr ^ K;
          cnt = 0;
          if (rnd_dly) dly = $urandom_range(0, 3);
        end else begin
          imem.imem_ack = 1'b0;
          imem.imem_rdata = $urandom;
          cnt++;
        end
      end else begin
        imem.imem_ack = 1'b0;
        cnt = 0;
      end
      prev_hold = clear_n && imem.imem_req && !imem.imem_ack;
      prev_addr = imem.imem_addr;
    end
  end

  initial begin
    imem2.imem_ack = 1'b0;
    imem2.imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      imem2.imem_ack = imem2.imem_req;
      imem2.imem_rdata = imem2.imem_addr ^ K;
    end
  end

  // One cycle: drive inputs shortly after negedge, then check the stream model
  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    @(negedge clock);
    #1;
    stall = s;
    redirect = r;
    redirect_pc = rp;
    #1;
    if (s || r) begin
      chk("write_blocked", {31'h0, if_write}, 32'h0);
    end else if (if_write === 1'b1) begin
      chk("instr", instr_out, exp_addr ^ K);
      chk("next_pc", next_pc_out, exp_addr + 32'h4);
      exp_addr = exp_addr + 32'h4;
      consumed++;
    end
    if (r) exp_addr = rp & ~32'h3;
  endtask

  initial begin
    int n;
    int c0;
    logic s, r;
    logic [31:0] rp;

    // Reset state
    clear_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req", {31'h0, imem.imem_req}, 32'h0);
    chk("rst_write", {31'h0, if_write}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_npc", next_pc_out, 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    clear_n = 1'b1;
    #1;
    chk("idle_after_rst", {31'h0, imem.imem_req}, 32'h0);

    // Streaming with single-cycle acks
    step(0, 0, 0);
    chk("first_req", {31'h0, imem.imem_req}, 32'h1);
    chk("first_addr", imem.imem_addr, 32'h0);
    chk("first_lat", {31'h0, if_write}, 32'h0);
    chk("wrap_addr0", imem2.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("first_write", {31'h0, if_write}, 32'h1);
    chk("wrap_addr1", imem2.imem_addr, 32'h0);
    chk("wrap_write", {31'h0, if_write2}, 32'h1);
    chk("wrap_npc", npc2, 32'h0);
    chk("wrap_instr", instr2, 32'hFFFF_FFFC ^ K);
    repeat (8) begin
      step(0, 0, 0);
      chk("throughput", {31'h0, if_write}, 32'h1);
    end

    // Stall for 4 cycles: buffer fills, fetch idles, output holds
    step(1, 0, 0);
    chk("stall_hold", instr_out, exp_addr ^ K);
    repeat (3) begin
      step(1, 0, 0);
      chk("stall_noreq", {31'h0, imem.imem_req}, 32'h0);
      chk("stall_hold", instr_out, exp_addr ^ K);
    end
    step(0, 0, 0);
    chk("release_w0", {31'h0, if_write}, 32'h1);
    step(0, 0, 0);
    chk("release_w1", {31'h0, if_write}, 32'h1);
    repeat (4) step(0, 0, 0);

    // Redirect with a request in flight (late ack), low target bits ignored
    dly = 3;
    n = 0;
    do begin step(0, 0, 0); n++; end while (imem.imem_ack !== 1'b1 && n < 20);
    chk("ack_seen", {31'h0, imem.imem_ack}, 32'h1);
    step(0, 1, 32'h103);
    chk("inflight_req", {31'h0, imem.imem_req}, 32'h1);
    chk("inflight_noack", {31'h0, imem.imem_ack}, 32'h0);
    n = 0;
    do begin
      step(0, 0, 0);
      chk("drain_nowrite", {31'h0, if_write}, 32'h0);
      n++;
    end while (imem.imem_ack !== 1'b1 && n < 10);
    chk("drain_ack", {31'h0, imem.imem_ack}, 32'h1);
    step(0, 0, 0);
    chk("redir_req", {31'h0, imem.imem_req}, 32'h1);
    chk("redir_addr", imem.imem_addr, 32'h100);
    n = 0;
    do begin step(0, 0, 0); n++; end while (if_write !== 1'b1 && n < 20);
    chk("redir_instr", instr_out, 32'h100 ^ K);
    chk("redir_npc", next_pc_out, 32'h104);
    dly = 0;

    // Redirect and stall together with both entries full
    repeat (3) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    chk("full_noreq", {31'h0, imem.imem_req}, 32'h0);
    step(1, 1, 32'h200);
    step(0, 0, 0);
    chk("flushed", {31'h0, if_write}, 32'h0);
    chk("restart_req", {31'h0, imem.imem_req}, 32'h1);
    chk("restart_addr", imem.imem_addr, 32'h200);
    step(0, 0, 0);
    chk("restart_write", {31'h0, if_write}, 32'h1);

    // Asynchronous reset in the middle of a request
    repeat (2) step(0, 0, 0);
    @(negedge clock);
    #1;
    clear_n = 1'b0;
    #1;
    chk("async_req", {31'h0, imem.imem_req}, 32'h0);
    chk("async_write", {31'h0, if_write}, 32'h0);
    @(negedge clock);
    #1;
    clear_n = 1'b1;
    exp_addr = 32'h0;
    #1;
    chk("rerst_idle", {31'h0, imem.imem_req}, 32'h0);
    step(0, 0, 0);
    chk("rerst_req", {31'h0, imem.imem_req}, 32'h1);
    chk("rerst_addr", imem.imem_addr, 32'h0);
    step(0, 0, 0);
    chk("rerst_write", {31'h0, if_write}, 32'h1);

    // Random traffic
    rnd_dly = 1'b1;
    repeat (3000) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 4);
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
      step(s, r, rp);
    end

    // Liveness once traffic settles
    rnd_dly = 1'b0;
    dly = 0;
    c0 = consumed;
    repeat (10) step(0, 0, 0);
    chk("progress", {31'h0, (consumed - c0) >= 5}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
